// File: rtl/stream_packetizer_pkg.sv
// ============================================================================
// Module      : stream_packetizer_pkg
// Description : Shared constants for the stream packetizer (FSM encoding,
//               default packet length).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_packetizer_pkg;

    localparam int unsigned    c_state_width    = 1;
    localparam logic [0:0]     c_state_idle     = 1'b0;
    localparam logic [0:0]     c_state_run      = 1'b1;

    // Length-minus-one value for a 4-word packet
    localparam int unsigned    c_default_length = 3;

endpackage

`default_nettype wire

// File: rtl/stream_packetizer_output_register.sv
// ============================================================================
// Module      : stream_packetizer_output_register
// Description : Single valid/ready register slice carrying data plus a last
//               flag, with ready derived combinationally from the output side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_packetizer_output_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_valid;

    // Free when empty or being emptied this cycle, so back-to-back words flow
    assign in_ready = ~r_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_data  <= in_data;
            r_last  <= in_last;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/stream_packetizer.sv
// ============================================================================
// Module      : stream_packetizer
// Description : Cuts a valid/ready word stream into fixed-length packets,
//               flagging the final word with out_last, and counts packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_packetizer
    import stream_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNTR_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_length,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [31:0]           sts_packets
);

    logic [c_state_width-1:0] r_state;
    logic [c_state_width-1:0] w_state_next;
    logic [CNTR_WIDTH-1:0]    r_cnt;
    logic [CNTR_WIDTH-1:0]    r_len;
    logic                     w_run;
    logic                     w_slice_valid;
    logic                     w_slice_ready;
    logic                     w_in_hs;
    logic                     w_pkt_end;

    assign w_in_hs   = in_valid & in_ready;
    assign w_pkt_end = (r_cnt == r_len);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= c_state_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_state_idle: begin
                if (enable) begin
                    w_state_next = c_state_run;
                end
            end
            c_state_run: begin
                if (w_in_hs && w_pkt_end && !enable) begin
                    w_state_next = c_state_idle;
                end
            end
            default: begin
                w_state_next = c_state_idle;
            end
        endcase
    end

    always_comb begin
        w_run         = (r_state == c_state_run);
        w_slice_valid = in_valid & w_run;
        in_ready      = w_run & w_slice_ready;
    end

    // Length is only sampled at a packet boundary, so mid-packet cfg changes wait
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt <= '0;
            r_len <= '0;
        end else if ((r_state == c_state_idle) && enable) begin
            r_cnt <= '0;
            r_len <= cfg_length;
        end else if (w_in_hs) begin
            if (w_pkt_end) begin
                r_cnt <= '0;
                if (enable) begin
                    r_len <= cfg_length;
                end
            end else begin
                r_cnt <= r_cnt + CNTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sts_packets <= '0;
        end else if (out_valid && out_ready && out_last) begin
            sts_packets <= sts_packets + 32'd1;
        end
    end

    stream_packetizer_output_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_output_register (
        .clk       (aclk),
        .rst       (areset),
        .in_data   (in_data),
        .in_last   (w_pkt_end),
        .in_valid  (w_slice_valid),
        .in_ready  (w_slice_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_stream_packetizer.sv
// ============================================================================
// Module      : tb_stream_packetizer
// Description : Directed self-checking bench for stream_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_packetizer;

    localparam int DATA_WIDTH = 32;
    localparam int CNTR_WIDTH = 16;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [CNTR_WIDTH-1:0] cfg_length;
    logic                  enable;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [31:0]           sts_packets;

    int checks = 0;
    int errors = 0;

    logic [32:0]           exp_q[$];
    logic                  in_hs;
    logic                  stall_prev = 1'b0;
    logic [DATA_WIDTH-1:0] stall_data;
    logic                  stall_last;

    always #5 aclk = ~aclk;

    stream_packetizer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNTR_WIDTH (CNTR_WIDTH)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cfg_length  (cfg_length),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .sts_packets (sts_packets)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then return 1 time unit after the edge
    task automatic step();
        logic [32:0] e;
        @(negedge aclk);
        in_hs = in_valid & in_ready;
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(stall_data));
            chk("stall_last", 64'(out_last), 64'(stall_last));
        end
        stall_prev = out_valid & ~out_ready;
        stall_data = out_data;
        stall_last = out_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e[31:0]));
                chk("out_last", 64'(out_last), 64'(e[32]));
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic push_exp(input int first, input int n, input int period);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(period == 0) ? 1'b1 : (((first + k) % period) == period - 1),
                             32'(first + k)});
        end
    endtask

    task automatic send(input int first, input int n, input bit rnd, output int cycles);
        int idx;
        idx    = 0;
        cycles = 0;
        in_valid = 1'b1;
        while (idx < n) begin
            in_data   = 32'(first + idx);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cycles++;
            if (in_hs) idx++;
            if (cycles > 400) begin
                chk("send_timeout", 64'(cycles), 64'd400);
                break;
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        areset    = 1'b1;
        step();
        areset    = 1'b0;
    endtask

    initial begin
        int cyc;
        areset     = 1'b1;
        cfg_length = '0;
        enable     = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        areset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_sts", 64'(sts_packets), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Length 4, continuous: 1 IDLE cycle then one word per cycle
        cfg_length = 16'd3;
        enable     = 1'b1;
        push_exp(0, 12, 4);
        send(0, 12, 1'b0, cyc);
        chk("t1_cycles", 64'(cyc), 64'd13);
        drain();
        chk("t1_sts", 64'(sts_packets), 64'd3);

        // Backpressure with length 2
        do_reset();
        cfg_length = 16'd1;
        enable     = 1'b1;
        push_exp(0, 12, 2);
        send(0, 12, 1'b1, cyc);
        drain();
        chk("t2_sts", 64'(sts_packets), 64'd6);

        // Length change mid-packet takes effect at the boundary
        do_reset();
        cfg_length = 16'd3;
        enable     = 1'b1;
        push_exp(0, 4, 4);
        push_exp(4, 4, 0);
        send(0, 2, 1'b0, cyc);
        cfg_length = 16'd0;
        send(2, 6, 1'b0, cyc);
        drain();
        chk("t3_sts", 64'(sts_packets), 64'd5);

        // Enable drop mid-packet: packet completes, then upstream is held off
        do_reset();
        cfg_length = 16'd7;
        enable     = 1'b1;
        push_exp(0, 8, 8);
        send(0, 3, 1'b0, cyc);
        enable = 1'b0;
        send(3, 5, 1'b0, cyc);
        in_data = 32'd99;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_idle_in_ready", 64'(in_ready), 64'd0);
            chk("t4_idle_no_hs", 64'(in_hs), 64'd0);
        end
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_sts", 64'(sts_packets), 64'd1);

        // Reset after word 5 of an 8-word packet
        do_reset();
        cfg_length = 16'd7;
        enable     = 1'b1;
        push_exp(0, 6, 8);
        exp_q[5][32] = 1'b0;
        send(0, 6, 1'b0, cyc);
        do_reset();
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_sts", 64'(sts_packets), 64'd0);
        in_valid = 1'b1;
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({(k == 7), 32'(100 + k)});
        end
        send(100, 8, 1'b0, cyc);
        drain();
        chk("t5_sts_after", 64'(sts_packets), 64'd1);

        // Single-word packets
        do_reset();
        cfg_length = 16'd0;
        enable     = 1'b1;
        push_exp(200, 10, 0);
        send(200, 10, 1'b0, cyc);
        drain();
        chk("t6_sts", 64'(sts_packets), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
